// File: rtl/umi_width_narrow_pkg.sv
// Shared UMI command-field layout and beat-sizing helpers for the width
// down-converter.
package umi_width_narrow_pkg;

  localparam int CMD_OPCODE_LSB = 0;
  localparam int CMD_OPCODE_W   = 5;
  localparam int CMD_SIZE_LSB   = 5;
  localparam int CMD_SIZE_W     = 3;
  localparam int CMD_LEN_LSB    = 8;
  localparam int CMD_LEN_W      = 8;
  localparam int CMD_EOM_BIT    = 22;

  // (LEN+1) << SIZE tops out at 256*128 bytes, so 17 bits never overflow
  localparam int BW = 17;
  typedef logic [BW-1:0] bytes_t;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SPLIT = 1'b1;

  function automatic bytes_t txn_bytes(input logic [CMD_LEN_W-1:0] len,
                                       input logic [CMD_SIZE_W-1:0] size);
    return (bytes_t'(len) + bytes_t'(1)) << size;
  endfunction

  function automatic logic [CMD_LEN_W-1:0] beat_len(input bytes_t rem,
                                                    input bytes_t cap,
                                                    input logic [CMD_SIZE_W-1:0] size);
    bytes_t bk;
    bytes_t units;
    bk    = (rem < cap) ? rem : cap;
    units = (bk >> size) - bytes_t'(1);
    return units[CMD_LEN_W-1:0];
  endfunction

endpackage

// File: rtl/umi_width_narrow_if.sv
// UMI request bundle: valid/ready handshake plus command, addresses and payload.
interface umi_width_narrow_if #(
  parameter int CW = 32,
  parameter int AW = 64,
  parameter int DW = 128
) ();

  logic          valid;
  logic [CW-1:0] cmd;
  logic [AW-1:0] dstaddr;
  logic [AW-1:0] srcaddr;
  logic [DW-1:0] data;
  logic          ready;

  modport master (output valid, cmd, dstaddr, srcaddr, data, input ready);
  modport slave  (input valid, cmd, dstaddr, srcaddr, data, output ready);

endinterface

// File: rtl/umi_width_narrow_fifo.sv
// la_syncfifo: DEPTH-entry single-clock FIFO with a registered ready (not full)
// and a combinational head read.
module la_syncfifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 2
) (
  input  logic          slowclk,
  input  logic          nreset,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          empty,
  output logic          ready
);

  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);

  logic [DW-1:0]   mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            ready_q, ready_d;
  logic            push, pull;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    push     = wr_en & ready_q;
    pull     = rd_en & (count_q != '0);
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pull ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + CNTW'(push) - CNTW'(pull);
    // ready is computed from the next occupancy so it never depends on rd_en combinationally
    ready_d  = (count_d != CNTW'(DEPTH));
  end

  always_ff @(posedge slowclk or negedge nreset) begin
    if (!nreset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
    end
  end

  always_ff @(posedge slowclk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign empty   = (count_q == '0);
  assign ready   = ready_q;

endmodule

// File: rtl/umi_width_narrow.sv
// UMI width down-converter: buffers IDW-wide transactions and re-emits each
// as ODW-wide beats with per-beat LEN, EOM and address rewrite.
module umi_width_narrow
  import umi_width_narrow_pkg::*;
#(
  parameter int CW    = 32,
  parameter int AW    = 64,
  parameter int IDW   = 512,
  parameter int ODW   = 128,
  parameter int DEPTH = 2
) (
  input  logic               slowclk,
  input  logic               nreset,
  umi_width_narrow_if.slave  umi_in,
  umi_width_narrow_if.master umi_out,
  output logic               error,
  output logic               busy
);

  localparam int FW     = CW + 2 * AW + IDW;
  localparam int CBYTES = ODW / 8;
  localparam int CSH    = $clog2(CBYTES);
  localparam int KW     = (IDW / ODW > 1) ? $clog2(IDW / ODW) : 1;

  logic [FW-1:0]  head;
  logic           empty, pop, in_ready;
  logic [CW-1:0]  head_cmd;
  logic [AW-1:0]  head_dst, head_src;
  logic [IDW-1:0] head_data, head_shift;

  la_syncfifo #(.DW(FW), .DEPTH(DEPTH)) u_buf (
    .slowclk (slowclk),
    .nreset  (nreset),
    .wr_en   (umi_in.valid),
    .wr_data ({umi_in.cmd, umi_in.dstaddr, umi_in.srcaddr, umi_in.data}),
    .rd_en   (pop),
    .rd_data (head),
    .empty   (empty),
    .ready   (in_ready)
  );

  assign umi_in.ready = in_ready;
  assign head_cmd     = head[FW-1 -: CW];
  assign head_dst     = head[FW-CW-1 -: AW];
  assign head_src     = head[IDW+AW-1 -: AW];
  assign head_data    = head[IDW-1:0];

  logic [0:0]      state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic            out_valid_q, out_valid_d;
  logic [CW-1:0]   out_cmd_q, out_cmd_d;
  logic [AW-1:0]   out_dst_q, out_dst_d;
  logic [AW-1:0]   out_src_q, out_src_d;
  logic [ODW-1:0]  out_data_q, out_data_d;
  logic            error_q, error_d;

  logic [CMD_SIZE_W-1:0] head_size;
  bytes_t          head_b, beat_off_b, rem;
  logic            head_legal, last, can_load, issue, discard;

  assign head_shift = head_data >> (ODW * int'(k_q));

  always_comb begin
    head_size  = head_cmd[CMD_SIZE_LSB +: CMD_SIZE_W];
    head_b     = txn_bytes(head_cmd[CMD_LEN_LSB +: CMD_LEN_W], head_size);
    head_legal = ((bytes_t'(1) << head_size) <= bytes_t'(CBYTES)) &&
                 (head_b <= bytes_t'(IDW / 8));
    beat_off_b = bytes_t'(k_q) << CSH;
    rem        = head_b - beat_off_b;
    last       = (rem <= bytes_t'(CBYTES));
    // the output register is a one-deep skid: refill whenever it empties this cycle
    can_load   = ~out_valid_q | umi_out.ready;
    issue      = ~empty & head_legal & can_load;
    discard    = ~empty & ~head_legal;
    pop        = discard | (issue & last);

    state_d     = state_q;
    k_d         = k_q;
    out_valid_d = out_valid_q;
    out_cmd_d   = out_cmd_q;
    out_dst_d   = out_dst_q;
    out_src_d   = out_src_q;
    out_data_d  = out_data_q;
    error_d     = error_q | discard;

    if (issue) begin
      out_valid_d = 1'b1;
      out_cmd_d   = head_cmd;
      out_cmd_d[CMD_LEN_LSB +: CMD_LEN_W] = beat_len(rem, bytes_t'(CBYTES), head_size);
      out_cmd_d[CMD_EOM_BIT] = last & head_cmd[CMD_EOM_BIT];
      out_dst_d   = head_dst + AW'(beat_off_b);
      out_src_d   = head_src + AW'(beat_off_b);
      out_data_d  = head_shift[ODW-1:0];
      if (last) begin
        k_d     = '0;
        state_d = ST_IDLE;
      end else begin
        k_d     = k_q + KW'(1);
        state_d = ST_SPLIT;
      end
    end else if (umi_out.ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge slowclk or negedge nreset) begin
    if (!nreset) begin
      state_q     <= ST_IDLE;
      k_q         <= '0;
      out_valid_q <= 1'b0;
      out_cmd_q   <= '0;
      out_dst_q   <= '0;
      out_src_q   <= '0;
      out_data_q  <= '0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      out_valid_q <= out_valid_d;
      out_cmd_q   <= out_cmd_d;
      out_dst_q   <= out_dst_d;
      out_src_q   <= out_src_d;
      out_data_q  <= out_data_d;
      error_q     <= error_d;
    end
  end

  assign umi_out.valid   = out_valid_q;
  assign umi_out.cmd     = out_cmd_q;
  assign umi_out.dstaddr = out_dst_q;
  assign umi_out.srcaddr = out_src_q;
  assign umi_out.data    = out_data_q;
  assign error           = error_q;
  assign busy            = ~empty | (state_q == ST_SPLIT);

endmodule

// File: tb/tb_umi_width_narrow.sv
// Scoreboard bench for umi_width_narrow: a byte-level model predicts each
// output beat; an independent monitor pops and compares on every transfer.
module tb_umi_width_narrow;

  localparam int CW = 32, AW = 64, IDW = 512, ODW = 128, DEPTH = 2;
  localparam int C  = ODW / 8;

  logic slowclk = 1'b0;
  logic nreset  = 1'b0;
  logic error, busy;

  umi_width_narrow_if #(.CW(CW), .AW(AW), .DW(IDW)) umi_in ();
  umi_width_narrow_if #(.CW(CW), .AW(AW), .DW(ODW)) umi_out ();

  umi_width_narrow #(.CW(CW), .AW(AW), .IDW(IDW), .ODW(ODW), .DEPTH(DEPTH)) dut (
    .slowclk (slowclk),
    .nreset  (nreset),
    .umi_in  (umi_in),
    .umi_out (umi_out),
    .error   (error),
    .busy    (busy)
  );

  always #5 slowclk = ~slowclk;

  typedef struct {
    logic [CW-1:0]  cmd;
    logic [AW-1:0]  dst;
    logic [AW-1:0]  src;
    logic [ODW-1:0] data;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  logic  exp_error = 1'b0;
  logic  rnd_ready = 1'b0;

  task automatic check_val(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: bytes = (LEN+1)*2^SIZE, carved into C-byte chunks
  task automatic model_push(input logic [CW-1:0] cmd, input logic [AW-1:0] dst,
                            input logic [AW-1:0] src, input logic [IDW-1:0] d);
    int size, len, nbytes, nbeats, bk;
    beat_t e;
    size   = int'(cmd[7:5]);
    len    = int'(cmd[15:8]);
    nbytes = (len + 1) * (2 ** size);
    if ((2 ** size) > C || nbytes > IDW / 8) begin
      exp_error = 1'b1;
      return;
    end
    nbeats = (nbytes + C - 1) / C;
    for (int k = 0; k < nbeats; k++) begin
      bk = nbytes - k * C;
      if (bk > C) bk = C;
      e.cmd        = cmd;
      e.cmd[15:8]  = 8'(bk / (2 ** size) - 1);
      e.cmd[22]    = (k == nbeats - 1) ? cmd[22] : 1'b0;
      e.dst        = dst + AW'(k * C);
      e.src        = src + AW'(k * C);
      for (int j = 0; j < C; j++) e.data[8*j +: 8] = d[8*(k*C + j) +: 8];
      exp_q.push_back(e);
    end
  endtask

  function automatic logic [CW-1:0] mk_cmd(input int size, input int len, input logic eom);
    logic [CW-1:0] c;
    c       = $urandom;
    c[7:5]  = 3'(size);
    c[15:8] = 8'(len);
    c[22]   = eom;
    return c;
  endfunction

  function automatic logic [IDW-1:0] rand_data();
    logic [IDW-1:0] d;
    for (int i = 0; i < IDW / 32; i++) d[32*i +: 32] = $urandom;
    return d;
  endfunction

  task automatic send(input logic [CW-1:0] cmd, input logic [AW-1:0] dst,
                      input logic [AW-1:0] src, input logic [IDW-1:0] d);
    int t = 0;
    @(negedge slowclk);
    umi_in.valid   = 1'b1;
    umi_in.cmd     = cmd;
    umi_in.dstaddr = dst;
    umi_in.srcaddr = src;
    umi_in.data    = d;
    while (!umi_in.ready && t < 1000) begin
      @(negedge slowclk);
      t++;
    end
    if (t >= 1000) begin
      check_val("in_ready_timeout", 160'(umi_in.ready), 160'(1));
      umi_in.valid = 1'b0;
      return;
    end
    @(posedge slowclk);
    model_push(cmd, dst, src, d);
    #1 umi_in.valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || umi_out.valid || busy) && t < 4000) begin
      @(negedge slowclk);
      t++;
    end
    check_val("drain_queue_empty", 160'(exp_q.size()), 160'(0));
  endtask

  always begin
    @(posedge slowclk);
    #1 umi_out.ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: compare on each accepted beat, check stability while stalled
  logic           stalled = 1'b0;
  logic [CW-1:0]  h_cmd;
  logic [AW-1:0]  h_dst, h_src;
  logic [ODW-1:0] h_data;
  always begin
    beat_t e;
    @(negedge slowclk);
    if (!nreset) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check_val("hold_valid", 160'(umi_out.valid), 160'(1));
        check_val("hold_cmd_dst", {umi_out.cmd, umi_out.dstaddr}, {h_cmd, h_dst});
        check_val("hold_src", 160'(umi_out.srcaddr), 160'(h_src));
        check_val("hold_data", 160'(umi_out.data), 160'(h_data));
      end
      if (umi_out.valid && umi_out.ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat actual cmd=%h dst=%h expected no beat",
                   umi_out.cmd, umi_out.dstaddr);
        end else begin
          e = exp_q.pop_front();
          check_val("beat_cmd", 160'(umi_out.cmd), 160'(e.cmd));
          check_val("beat_dst", 160'(umi_out.dstaddr), 160'(e.dst));
          check_val("beat_src", 160'(umi_out.srcaddr), 160'(e.src));
          check_val("beat_data", 160'(umi_out.data), 160'(e.data));
        end
      end
      stalled = umi_out.valid & ~umi_out.ready;
      h_cmd   = umi_out.cmd;
      h_dst   = umi_out.dstaddr;
      h_src   = umi_out.srcaddr;
      h_data  = umi_out.data;
    end
  end

  initial begin
    logic [IDW-1:0] d;
    int size, len;
    umi_in.valid = 1'b0;
    umi_in.cmd = '0; umi_in.dstaddr = '0; umi_in.srcaddr = '0; umi_in.data = '0;
    umi_out.ready = 1'b1;
    repeat (2) @(posedge slowclk);
    #1;
    check_val("rst_in_ready", 160'(umi_in.ready), 160'(0));
    check_val("rst_out_valid", 160'(umi_out.valid), 160'(0));
    check_val("rst_busy", 160'(busy), 160'(0));
    check_val("rst_error", 160'(error), 160'(0));
    check_val("rst_out_cmd_dst", {umi_out.cmd, umi_out.dstaddr}, 160'(0));
    check_val("rst_out_data", 160'(umi_out.data), 160'(0));
    @(negedge slowclk) nreset = 1'b1;
    @(posedge slowclk); #1;
    check_val("in_ready_after_rst", 160'(umi_in.ready), 160'(1));

    // 64-byte write split into four 16-byte beats; data bytes are 0,1,2,...
    for (int i = 0; i < IDW / 8; i++) d[8*i +: 8] = 8'(i);
    send(mk_cmd(0, 63, 1'b1), 64'h1000, 64'h2000, d);
    drain();

    // single-beat pass-through with one-cycle latency
    send(mk_cmd(3, 1, 1'b1), 64'h3000, 64'h4000, rand_data());
    check_val("latency_not_early", 160'(umi_out.valid), 160'(0));
    @(posedge slowclk); #1;
    check_val("latency_one_cycle", 160'(umi_out.valid), 160'(1));
    drain();

    // 17 bytes: one full beat then a one-byte tail
    send(mk_cmd(0, 16, 1'b1), 64'hFFFF_FFFF_FFFF_FFF8, 64'h5000, rand_data());
    drain();

    // SIZE=5 exceeds the beat: dropped, sticky error, next packet unaffected
    check_val("error_clear", 160'(error), 160'(0));
    send(mk_cmd(5, 0, 1'b1), 64'h6000, 64'h7000, rand_data());
    repeat (3) @(posedge slowclk);
    #1;
    check_val("error_set", 160'(error), 160'(1));
    check_val("illegal_no_busy", 160'(busy), 160'(0));
    send(mk_cmd(2, 5, 1'b0), 64'h8000, 64'h9000, rand_data());
    drain();

    // randomized mix under 50% downstream backpressure
    rnd_ready = 1'b1;
    for (int p = 0; p < 200; p++) begin
      if ($urandom_range(0, 9) == 0) begin
        if ($urandom_range(0, 1) == 1) begin
          size = $urandom_range(5, 7);
          len  = $urandom_range(0, 255);
        end else begin
          size = 0;
          len  = $urandom_range(64, 255);
        end
      end else begin
        size = $urandom_range(0, 4);
        len  = $urandom_range(0, (64 >> size) - 1);
      end
      send(mk_cmd(size, len, 1'($urandom_range(0, 1))),
           {$urandom, $urandom}, {$urandom, $urandom}, rand_data());
    end
    drain();
    rnd_ready = 1'b0;
    repeat (2) @(posedge slowclk);
    check_val("error_sticky", 160'(error), 160'(exp_error));

    // reset while beat 2 of a 4-beat split is presented, second packet buffered
    send(mk_cmd(0, 63, 1'b1), 64'hA000, 64'hB000, rand_data());
    send(mk_cmd(0, 63, 1'b1), 64'hC000, 64'hD000, rand_data());
    @(posedge slowclk);
    @(posedge slowclk);
    #1;
    nreset = 1'b0;
    exp_q.delete();
    exp_error = 1'b0;
    #1;
    check_val("midrst_out_valid", 160'(umi_out.valid), 160'(0));
    check_val("midrst_busy", 160'(busy), 160'(0));
    check_val("midrst_error", 160'(error), 160'(0));
    check_val("midrst_in_ready", 160'(umi_in.ready), 160'(0));
    check_val("midrst_out_cmd_dst", {umi_out.cmd, umi_out.dstaddr}, 160'(0));
    check_val("midrst_out_data", 160'(umi_out.data), 160'(0));
    repeat (3) @(posedge slowclk);
    @(negedge slowclk) nreset = 1'b1;
    @(posedge slowclk); #1;
    check_val("postrst_in_ready", 160'(umi_in.ready), 160'(1));
    repeat (10) @(posedge slowclk);
    #1;
    check_val("postrst_idle_busy", 160'(busy), 160'(0));
    check_val("postrst_idle_valid", 160'(umi_out.valid), 160'(0));
    send(mk_cmd(1, 15, 1'b1), 64'hE000, 64'hF000, rand_data());
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
